wb_stage: RTL
=============

// Module: wb_stage
// PURPOSE
// - Writeback stage directly upstream of the 32x32 register file; sole driver of its RegWrite, Wt_addr, Wt_data.
// - Registers MEM-stage results (MEM/WB pipeline register) and selects the writeback source.
// - Merges late results from the long-latency unit (divider) through a small FIFO and arbitrates them into free writeback slots.
// - Raises a starvation stall toward the pipeline when the FIFO is blocked too long.
// PARAMETERS
// - LU_DEPTH     2   entries in long-latency result FIFO (power of 2, >=2)
// - STARVE_LIMIT 4   consecutive full-and-blocked cycles before stall_req asserts (>=1)
// PORTS
// - clk           in   1   clock
// - rst           in   1   reset, asynchronous, active-high
// - mem_valid     in   1   MEM stage holds a valid instruction
// - mem_reg_write in   1   instruction writes rd
// - mem_rd        in   5   destination register
// - mem_wb_sel    in   2   source: 00 ALU, 01 load, 10 PC+4, 11 immediate
// - mem_alu_res   in   32  ALU result
// - mem_load_data in   32  load data (already extended)
// - mem_pc4       in   32  PC+4
// - mem_imm       in   32  immediate (LUI)
// - lu_valid      in   1   long-latency result offered
// - lu_ready      out  1   FIFO accepts; = !fifo_full
// - lu_rd         in   5   long-latency destination
// - lu_data       in   32  long-latency result
// - RegWrite      out  1   register file write enable
// - Wt_addr       out  5   register file write address
// - Wt_data       out  32  register file write data
// - stall_req     out  1   request upstream bubble (registered)
// BEHAVIOUR
// - WB register: every posedge captures wb_valid<=mem_valid, wb_we<=mem_reg_write, wb_rd<=mem_rd, wb_data<=selected source; reset clears all to 0.
// - Latency: MEM inputs at edge N appear on RegWrite/Wt_* during cycle N+1; regfile commits at edge N+1.
// - pipe_wr = wb_valid & wb_we & (wb_rd!=0); rd=0 writes are dropped here, never forwarded.
// - Priority: pipe_wr=1 -> drive pipeline write; else if FIFO non-empty -> drive FIFO head, pop at the same edge; else RegWrite=0.
// - Outputs are combinational from WB register and FIFO head. When RegWrite=0: Wt_addr=0, Wt_data=0.
// - FIFO push when lu_valid & lu_ready. Entries with lu_rd=0 are accepted and discarded (no push).
// - Full FIFO with simultaneous pop: lu_ready stays 0 that cycle (no same-cycle bypass). Empty FIFO: lu_data never bypasses to outputs.
// - Pointers wrap modulo LU_DEPTH; occupancy counter 0..LU_DEPTH.
// - Starvation counter: increments when fifo_full & pipe_wr; clears otherwise.
// - stall_req: set at the edge where counter reaches STARVE_LIMIT; holds while fifo_full; clears the edge after FIFO is no longer full, with counter reset.
// - Upstream honours stall_req by presenting mem_valid=0; the next free slot drains the FIFO.
// - Ordering: same-rd races between FIFO and pipeline are prevented by the hazard unit; this block applies no rd matching.
// - Reset: RegWrite=0, Wt_addr=0, Wt_data=0, stall_req=0, FIFO empty, lu_ready=1 after deassertion.
// - Mid-operation reset: FIFO contents and in-flight WB entry are discarded.
// TESTING
// - mem_valid=1, we=1, rd=5, sel=00, alu=0x1234 -> next cycle RegWrite=1, Wt_addr=5, Wt_data=0x1234.
// - sel=10, pc4=0x104, rd=1 -> Wt_data=0x104; repeat with rd=0 -> RegWrite=0, Wt_addr=0, Wt_data=0.
// - Empty pipeline slot; push lu rd=7, data=0xDEAD -> one cycle later RegWrite=1, Wt_addr=7, Wt_data=0xDEAD; FIFO empty.
// - Back-to-back pipeline writes; push 2 lu results -> lu_ready=0. After 4 full-blocked cycles stall_req=1.
// - Continuing stall case: bubble drains head; lu_ready=1 next cycle; stall_req=0 next edge; both entries written in FIFO order.
// - Assert rst with FIFO holding 2 entries and a valid WB entry -> outputs 0 immediately; after release, no stale writes.

Source files
------------

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage
// Purpose  : Writeback stage in front of the 32x32 register file. It is the
//            only driver of the register file write port.
//            - Holds the MEM/WB pipeline register and picks the writeback
//              source (ALU, load, PC+4, immediate).
//            - Buffers late results from the long-latency unit (divider) in a
//              small FIFO. Each buffered result is written in the first cycle
//              that has no pipeline write.
//            - Raises a registered stall request when a full FIFO has been
//              blocked by pipeline writes for too long.
// Ports    : clk, rst (asynchronous, active-high)
//            mem_*      MEM-stage instruction (valid, reg_write, rd, wb_sel
//                       and the four candidate source values)
//            lu_valid / lu_ready / lu_rd / lu_data
//                       long-latency result handshake
//            RegWrite / Wt_addr / Wt_data
//                       register file write port
//            stall_req  asks upstream to insert bubbles
// Revision : 1.0 - initial release
// ============================================================================
module wb_stage #(
  parameter int LU_DEPTH     = 2,  // FIFO entries, power of 2, >= 2
  parameter int STARVE_LIMIT = 4   // blocked-while-full cycles before stall
) (
  input  logic        clk,
  input  logic        rst,
  // MEM stage
  input  logic        mem_valid,
  input  logic        mem_reg_write,
  input  logic [4:0]  mem_rd,
  input  logic [1:0]  mem_wb_sel,
  input  logic [31:0] mem_alu_res,
  input  logic [31:0] mem_load_data,
  input  logic [31:0] mem_pc4,
  input  logic [31:0] mem_imm,
  // long-latency unit
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,
  // register file write port
  output logic        RegWrite,
  output logic [4:0]  Wt_addr,
  output logic [31:0] Wt_data,
  // pipeline control
  output logic        stall_req
);

  // --------------------------------------------------------------------------
  // Parameter sanity
  // --------------------------------------------------------------------------
  if ((LU_DEPTH < 2) || ((LU_DEPTH & (LU_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("wb_stage: LU_DEPTH must be a power of 2 and at least 2");
  end
  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("wb_stage: STARVE_LIMIT must be at least 1");
  end

  // --------------------------------------------------------------------------
  // Local constants
  // --------------------------------------------------------------------------
  localparam int PTR_W = $clog2(LU_DEPTH);
  localparam int CNT_W = $clog2(LU_DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(LU_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);
  localparam logic [STV_W-1:0] STV_ONE    = STV_W'(1);

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;
  localparam logic [1:0] SEL_IMM  = 2'b11;

  // --------------------------------------------------------------------------
  // Signals
  // --------------------------------------------------------------------------
  // MEM/WB register
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] mem_sel_data;

  // long-latency FIFO
  logic [4:0]       fifo_rd   [LU_DEPTH];
  logic [31:0]      fifo_data [LU_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_cnt;
  logic             fifo_empty;
  logic             fifo_full;
  logic             fifo_push;
  logic             fifo_pop;

  // arbitration / starvation
  logic             pipe_wr;
  logic [STV_W-1:0] starve_cnt;
  logic [STV_W-1:0] starve_nxt;

  // --------------------------------------------------------------------------
  // Writeback source select
  // --------------------------------------------------------------------------
  always_comb begin
    mem_sel_data = mem_alu_res;
    case (mem_wb_sel)
      SEL_ALU:  mem_sel_data = mem_alu_res;
      SEL_LOAD: mem_sel_data = mem_load_data;
      SEL_PC4:  mem_sel_data = mem_pc4;
      SEL_IMM:  mem_sel_data = mem_imm;
      default:  mem_sel_data = mem_alu_res;
    endcase
  end

  // --------------------------------------------------------------------------
  // MEM/WB pipeline register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      wb_rd    <= 5'd0;
      wb_data  <= 32'd0;
    end else begin
      wb_valid <= mem_valid;
      wb_we    <= mem_reg_write;
      wb_rd    <= mem_rd;
      wb_data  <= mem_sel_data;
    end
  end

  // x0 is hard-wired to zero, so writes to it are dropped before arbitration
  // and never occupy the write port.
  assign pipe_wr = wb_valid & wb_we & (wb_rd != 5'd0);

  // --------------------------------------------------------------------------
  // Long-latency result FIFO
  // --------------------------------------------------------------------------
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == FULL_CNT);

  // Ready depends only on occupancy. A pop in the same cycle does not make
  // room early, so there is no combinational path from the arbiter to
  // lu_ready.
  assign lu_ready = ~fifo_full;

  // Results aimed at x0 complete the handshake but are never stored.
  assign fifo_push = lu_valid & lu_ready & (lu_rd != 5'd0);

  // The pipeline has priority; the FIFO head takes only an empty slot.
  assign fifo_pop = ~pipe_wr & ~fifo_empty;

  // The storage needs no reset: only the pointers and the count define
  // which entries are live.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_rd[wr_ptr]   <= lu_rd;
      fifo_data[wr_ptr] <= lu_data;
    end
  end

  // LU_DEPTH is a power of 2, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (fifo_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
        2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Register file write port
  // --------------------------------------------------------------------------
  // When idle, the port drives zeros rather than stale values.
  always_comb begin
    RegWrite = 1'b0;
    Wt_addr  = 5'd0;
    Wt_data  = 32'd0;
    if (pipe_wr) begin
      RegWrite = 1'b1;
      Wt_addr  = wb_rd;
      Wt_data  = wb_data;
    end else if (!fifo_empty) begin
      RegWrite = 1'b1;
      Wt_addr  = fifo_rd[rd_ptr];
      Wt_data  = fifo_data[rd_ptr];
    end
  end

  // --------------------------------------------------------------------------
  // Starvation detection
  // --------------------------------------------------------------------------
  // The counter tracks consecutive cycles in which the FIFO is full and a
  // pipeline write takes the port. It saturates at the limit, so a long
  // stall cannot wrap it.
  always_comb begin
    starve_nxt = '0;
    if (fifo_full && pipe_wr) begin
      starve_nxt = (starve_cnt == STARVE_MAX) ? starve_cnt : starve_cnt + STV_ONE;
    end
  end

  // The stall request rises on the edge where the counter reaches the limit.
  // It holds for as long as the FIFO stays full, even through bubbles that
  // clear the counter. It drops on the first edge after the FIFO has room.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
      stall_req  <= 1'b0;
    end else begin
      starve_cnt <= starve_nxt;
      if (!fifo_full) begin
        stall_req <= 1'b0;
      end else if (starve_nxt == STARVE_MAX) begin
        stall_req <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
